// File: rtl/fraction_reducer.sv
// Fraction reducer: divides num and den by their GCD with two restoring dividers.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid, in_ready       operand handshake for num, den and g
//   num, den, g              unsigned operands and their GCD
//   out_valid, out_ready     result handshake
//   num_red, den_red         num/g and den/g
//   err                      g==0, or a nonzero remainder in either division

module fraction_reducer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] den,
    input  logic [WIDTH-1:0] g,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] num_red,
    output logic [WIDTH-1:0] den_red,
    output logic             err
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd_n;
    logic [WIDTH-1:0] dvd_d;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] q_n;
    logic [WIDTH-1:0] q_d;

    // One restoring step per divider. The shifted remainder carries an
    // extra MSB so the shift never overflows; after a step the remainder
    // is below the divisor again and fits in WIDTH bits.
    logic [WIDTH:0] sh_n;
    logic [WIDTH:0] sh_d;
    logic [WIDTH:0] nx_n;
    logic [WIDTH:0] nx_d;
    logic           ge_n;
    logic           ge_d;

    always_comb begin
        sh_n = {rem_n, dvd_n[cnt]};
        sh_d = {rem_d, dvd_d[cnt]};
        ge_n = (sh_n >= {1'b0, dvs});
        ge_d = (sh_d >= {1'b0, dvs});
        nx_n = ge_n ? (sh_n - {1'b0, dvs}) : sh_n;
        nx_d = ge_d ? (sh_d - {1'b0, dvs}) : sh_d;
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            dvd_n     <= '0;
            dvd_d     <= '0;
            dvs       <= '0;
            rem_n     <= '0;
            rem_d     <= '0;
            q_n       <= '0;
            q_d       <= '0;
            out_valid <= 1'b0;
            num_red   <= '0;
            den_red   <= '0;
            err       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd_n <= num;
                        dvd_d <= den;
                        dvs   <= g;
                        rem_n <= '0;
                        rem_d <= '0;
                        q_n   <= '0;
                        q_d   <= '0;
                        cnt   <= CW'(WIDTH - 1);
                        if (g == '0) begin
                            // Division by zero: pass operands through.
                            state     <= DONE;
                            out_valid <= 1'b1;
                            num_red   <= num;
                            den_red   <= den;
                            err       <= 1'b1;
                        end else begin
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem_n <= nx_n[WIDTH-1:0];
                    rem_d <= nx_d[WIDTH-1:0];
                    q_n   <= {q_n[WIDTH-2:0], ge_n};
                    q_d   <= {q_d[WIDTH-2:0], ge_d};
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        num_red   <= {q_n[WIDTH-2:0], ge_n};
                        den_red   <= {q_d[WIDTH-2:0], ge_d};
                        err       <= (nx_n != '0) || (nx_d != '0);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fraction_reducer.sv
// Testbench for fraction_reducer: directed and random operations
// against an arithmetic reference model.

module tb_fraction_reducer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] num = '0;
    logic [W-1:0] den = '0;
    logic [W-1:0] g = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] num_red;
    logic [W-1:0] den_red;
    logic         err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fraction_reducer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .num      (num),
        .den      (den),
        .g        (g),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .num_red  (num_red),
        .den_red  (den_red),
        .err      (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, check latency, result and optional backpressure.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] d, input int hold);
        logic [W-1:0] en;
        logic [W-1:0] ed;
        logic         ee;
        int           k;
        en = (d == 0) ? a : a / d;
        ed = (d == 0) ? b : b / d;
        ee = (d == 0) || (a % d != 0) || (b % d != 0);
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        chk("idle_ready", 32'(in_ready), 32'd1);
        out_ready = (hold == 0);
        num = a;
        den = b;
        g = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        num = W'($urandom);
        den = W'($urandom);
        g = W'($urandom);
        chk("busy_ready", 32'(in_ready), 32'd0);
        k = 0;
        while (!out_valid && k < 3 * W) begin
            tick();
            k++;
        end
        chk("latency", 32'(k), (d == 0) ? 32'd0 : 32'(W));
        chk("num_red", 32'(num_red), 32'(en));
        chk("den_red", 32'(den_red), 32'(ed));
        chk("err", 32'(err), 32'(ee));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_num", 32'(num_red), 32'(en));
            chk("hold_den", 32'(den_red), 32'(ed));
            chk("hold_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("hs_valid", 32'(out_valid), 32'd0);
        chk("hs_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int a;
        int b;
        int d;

        #12;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_num", 32'(num_red), 32'd0);
        chk("rst_den", 32'(den_red), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_op(8'd48, 8'd18, 8'd6, 0);
        run_op(8'd255, 8'd255, 8'd255, 0);
        run_op(8'd0, 8'd7, 8'd7, 0);
        run_op(8'd48, 8'd18, 8'd0, 0);
        run_op(8'd48, 8'd18, 8'd5, 0);
        run_op(8'd100, 8'd75, 8'd25, 5);
        run_op(8'd200, 8'd13, 8'd1, 0);

        // Reset three cycles into DIV abandons the operation.
        num = 8'd48;
        den = 8'd18;
        g = 8'd6;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_ready", 32'(in_ready), 32'd1);
        chk("ar_num", 32'(num_red), 32'd0);
        chk("ar_den", 32'(den_red), 32'd0);
        chk("ar_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            chk("ar_no_valid", 32'(out_valid), 32'd0);
        end
        run_op(8'd12, 8'd8, 8'd4, 0);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                d = 0;
            end else begin
                d = int'($urandom_range(1, 255));
            end
            if (d != 0 && $urandom_range(0, 1) == 1) begin
                a = d * int'($urandom_range(0, 255 / d));
                b = d * int'($urandom_range(0, 255 / d));
            end else begin
                a = int'($urandom_range(0, 255));
                b = int'($urandom_range(0, 255));
            end
            run_op(W'(a), W'(b), W'(d), int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
